uart_tx_arbiter: RTL and testbench

Round-robin controller that shares the single UART transmitter between N_REQ byte producers inside the UART subsystem. It accepts one byte at a time from the winning requester and launches it on the transmitter with a one-cycle enable. It then waits for the transmitter's completion pulse and reports per-requester grant, completion and timeout status.

---
 rtl/uart_tx_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Launches one byte per grant and reports completion and timeout per transfer.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          sent_o,
  output logic                      timeout_o,
  output logic                      err_o,
  input  logic                      err_clr_i,
  output logic [$clog2(N_REQ)-1:0]  owner_o,
  output logic                      ctl_busy_o,
  output logic                      tx_en_o,
  output logic [DATA_W-1:0]         tx_data_o,
  input  logic                      tx_busy_i,
  input  logic                      tx_done_i
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    sent_q, sent_d;
  logic                timeout_q, timeout_d;
  logic                err_q, err_d;
  logic                ctl_busy_q, ctl_busy_d;
  logic                tx_en_q, tx_en_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;

  logic                win_found_s;
  logic [ID_W-1:0]     win_idx_s;
  logic [DATA_W-1:0]   win_data_s;
  logic [ID_W-1:0]     ptr_next_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin scan: first pending request starting at the pointer, wrapping.
  always_comb begin
    logic [ID_W:0] cand;
    cand        = '0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end else begin
        cand = cand;
      end
      if (!win_found_s && req_i[cand[ID_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand[ID_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Byte of the winning requester.
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx_s == ID_W'(i)) begin
        win_data_s = req_data_i[i*DATA_W +: DATA_W];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  assign ptr_next_s = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    timer_d   = timer_q;
    gnt_d     = '0;
    sent_d    = '0;
    timeout_d = 1'b0;
    tx_en_d   = 1'b0;
    tx_data_d = tx_data_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (enable_i && win_found_s && !tx_busy_i) begin
          owner_d   = win_idx_s;
          tx_data_d = win_data_s;
          gnt_d     = onehot(win_idx_s);
          tx_en_d   = 1'b1;
          state_d   = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end
      LAUNCH: begin
        timer_d = TMR_W'(1);
        if (tx_done_i) begin
          sent_d  = onehot(owner_q);
          ptr_d   = ptr_next_s;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        timer_d = timer_q + TMR_W'(1);
        if (tx_done_i) begin
          sent_d  = onehot(owner_q);
          ptr_d   = ptr_next_s;
          timer_d = '0;
          state_d = IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          // Expiry loses to a same-cycle tx_done; err set beats err_clr.
          timeout_d = 1'b1;
          err_d     = 1'b1;
          ptr_d     = ptr_next_s;
          timer_d   = '0;
          state_d   = IDLE;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase

    ctl_busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      timer_q    <= '0;
      gnt_q      <= '0;
      sent_q     <= '0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
      ctl_busy_q <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      timer_q    <= timer_d;
      gnt_q      <= gnt_d;
      sent_q     <= sent_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      ctl_busy_q <= ctl_busy_d;
      tx_en_q    <= tx_en_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign sent_o     = sent_q;
  assign timeout_o  = timeout_q;
  assign err_o      = err_q;
  assign owner_o    = owner_q;
  assign ctl_busy_o = ctl_busy_q;
  assign tx_en_o    = tx_en_q;
  assign tx_data_o  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a transaction-level model
// (round-robin pointer, done-delay window, sticky error flag).
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           enable_i = 1'b0;
  logic [N-1:0]   req_i = '0;
  logic [N*W-1:0] req_data_i = '0;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   sent_o;
  logic           timeout_o;
  logic           err_o;
  logic           err_clr_i = 1'b0;
  logic [1:0]     owner_o;
  logic           ctl_busy_o;
  logic           tx_en_o;
  logic [W-1:0]   tx_data_o;
  logic           tx_busy_i = 1'b0;
  logic           tx_done_i = 1'b0;

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .req_i(req_i),
    .req_data_i(req_data_i), .gnt_o(gnt_o), .sent_o(sent_o),
    .timeout_o(timeout_o), .err_o(err_o), .err_clr_i(err_clr_i),
    .owner_o(owner_o), .ctl_busy_o(ctl_busy_o), .tx_en_o(tx_en_o),
    .tx_data_o(tx_data_o), .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   failures = 0;
  int   ptr_m = 0;
  logic err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic step(input logic set_err);
    @(posedge clk_i);
    #1;
    if (rst_i) err_m = 1'b0;
    else if (set_err) err_m = 1'b1;
    else if (err_clr_i) err_m = 1'b0;
  endtask

  function automatic int pick(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (ptr_m + i) % N;
      if (m[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},  32'(gnt_o), 32'd0);
    chk({tag, "_sent"}, 32'(sent_o), 32'd0);
    chk({tag, "_to"},   32'(timeout_o), 32'd0);
    chk({tag, "_err"},  32'(err_o), 32'd0);
    chk({tag, "_own"},  32'(owner_o), 32'd0);
    chk({tag, "_busy"}, 32'(ctl_busy_o), 32'd0);
    chk({tag, "_txen"}, 32'(tx_en_o), 32'd0);
    chk({tag, "_txd"},  32'(tx_data_o), 32'd0);
  endtask

  // One transfer: optional blocked cycles, grant, then done after dly cycles
  // (dly > TO means no done -> timeout), or a reset rst_at cycles after launch.
  task automatic do_xfer(input logic [N-1:0] mask, input logic [N*W-1:0] data,
                         input int blk, input int dly, input int rst_at);
    int w;
    int lim;
    logic [N-1:0] oh;
    for (int b = 0; b < blk; b++) begin
      req_i = 4'($urandom_range(0, 15));
      req_data_i = $urandom;
      case ($urandom_range(0, 2))
        0: begin enable_i = 1'b0; tx_busy_i = 1'($urandom_range(0, 1)); end
        1: begin enable_i = 1'b1; tx_busy_i = 1'b1; end
        default: begin enable_i = 1'b1; tx_busy_i = 1'b0; req_i = '0; end
      endcase
      step(1'b0);
      chk("blk_gnt", 32'(gnt_o), 32'd0);
      chk("blk_txen", 32'(tx_en_o), 32'd0);
      chk("blk_busy", 32'(ctl_busy_o), 32'd0);
    end
    req_i = mask; req_data_i = data; enable_i = 1'b1; tx_busy_i = 1'b0;
    w = pick(mask);
    oh = '0; oh[w] = 1'b1;
    step(1'b0);
    chk("gnt", 32'(gnt_o), 32'(oh));
    chk("txen", 32'(tx_en_o), 32'd1);
    chk("txdata", 32'(tx_data_o), 32'(data[w*W +: W]));
    chk("owner", 32'(owner_o), 32'(w));
    chk("busy_launch", 32'(ctl_busy_o), 32'd1);
    chk("err_launch", 32'(err_o), 32'(err_m));
    req_i = '0; tx_busy_i = 1'b1;

    if (rst_at > 0) begin
      for (int k = 0; k < rst_at; k++) step(1'b0);
      chk("busy_prerst", 32'(ctl_busy_o), 32'd1);
      rst_i = 1'b1;
      step(1'b0);
      rst_i = 1'b0;
      chk_all_zero("rst_mid");
      tx_done_i = 1'b1;
      step(1'b0);
      tx_done_i = 1'b0;
      chk("rst_late_sent", 32'(sent_o), 32'd0);
      chk("rst_late_busy", 32'(ctl_busy_o), 32'd0);
      ptr_m = 0;
      tx_busy_i = 1'b0;
      return;
    end

    lim = (dly <= TO) ? dly : TO;
    for (int k = 0; k <= lim; k++) begin
      if (k > 0) begin
        chk("wait_gnt", 32'(gnt_o), 32'd0);
        chk("wait_txen", 32'(tx_en_o), 32'd0);
        chk("wait_busy", 32'(ctl_busy_o), 32'd1);
        chk("wait_sent", 32'(sent_o), 32'd0);
        chk("wait_to", 32'(timeout_o), 32'd0);
        chk("wait_err", 32'(err_o), 32'(err_m));
        chk("wait_txdata", 32'(tx_data_o), 32'(data[w*W +: W]));
      end
      tx_done_i = (k == dly);
      enable_i = 1'($urandom_range(0, 1));
      err_clr_i = ($urandom_range(0, 7) == 0);
      step(dly > TO && k == TO);
    end
    tx_done_i = 1'b0; err_clr_i = 1'b0;
    if (dly <= TO) begin
      chk("sent", 32'(sent_o), 32'(oh));
      chk("no_to", 32'(timeout_o), 32'd0);
    end else begin
      chk("to_sent", 32'(sent_o), 32'd0);
      chk("to_pulse", 32'(timeout_o), 32'd1);
    end
    chk("end_busy", 32'(ctl_busy_o), 32'd0);
    chk("end_txen", 32'(tx_en_o), 32'd0);
    chk("end_err", 32'(err_o), 32'(err_m));
    chk("end_owner", 32'(owner_o), 32'(w));
    ptr_m = (w + 1) % N;
    tx_busy_i = 1'b0;

    if ($urandom_range(0, 1) == 1) begin
      req_i = '0;
      tx_done_i = 1'b1;
      err_clr_i = 1'($urandom_range(0, 1));
      step(1'b0);
      tx_done_i = 1'b0; err_clr_i = 1'b0;
      chk("idle_done_sent", 32'(sent_o), 32'd0);
      chk("idle_done_busy", 32'(ctl_busy_o), 32'd0);
      chk("idle_err", 32'(err_o), 32'(err_m));
      chk("idle_to", 32'(timeout_o), 32'd0);
    end
  endtask

  initial begin
    int dly;
    int rat;
    logic [N-1:0] m;
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0);
    rst_i = 1'b0;
    chk_all_zero("reset");

    do_xfer(4'b0010, 32'h0000_A500, 0, 10, 0);
    for (int i = 0; i < 5; i++) do_xfer(4'b1111, $urandom, 0, 5, 0);
    do_xfer(4'b0010, $urandom, 0, 3, 0);
    do_xfer(4'b1001, $urandom, 0, 2, 0);
    do_xfer(4'b1001, $urandom, 0, 2, 0);
    do_xfer(4'b0100, $urandom, 0, TO + 1, 0);
    do_xfer(4'b0100, $urandom, 0, TO, 0);
    do_xfer(4'b0001, $urandom, 0, 0, 0);
    do_xfer(4'b1110, $urandom, 4, 1, 0);
    do_xfer(4'b1000, $urandom, 0, 0, 3);
    do_xfer(4'b1111, $urandom, 0, 4, 0);

    for (int n = 0; n < 150; n++) begin
      m = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 3))
        0: dly = $urandom_range(0, 2);
        1: dly = $urandom_range(TO - 1, TO + 2);
        default: dly = $urandom_range(0, TO + 2);
      endcase
      rat = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 5) : 0;
      do_xfer(m, $urandom, $urandom_range(0, 3), dly, rat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
